// File: rtl/mmio_spi_core.sv
// MMIO slot SPI master: one 8-bit full-duplex transfer per start write,
// SPI modes 0-3, programmable SCLK divider, software-driven slave selects.
module mmio_spi_core #(
    parameter int          S        = 1,
    parameter logic [15:0] DVSR_RST = 16'd49
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cs,
    input  logic          read,
    input  logic          write,
    input  logic [4:0]    addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   rd_data,
    output logic          spi_sclk,
    output logic          spi_mosi,
    input  logic          spi_miso,
    output logic [S-1:0]  spi_ss_n
);

    typedef enum logic [1:0] {IDLE, CPHA_DLY, P0, P1} state_t;

    state_t         state_reg;
    logic [S-1:0]   ss_n_reg;
    logic [15:0]    dvsr_reg;
    logic           cpol_reg;
    logic           cpha_reg;
    logic [7:0]     tx_reg;
    logic [7:0]     rx_shift_reg;
    logic [7:0]     rx_data_reg;
    logic [15:0]    cnt_reg;
    logic [2:0]     n_reg;
    logic           sclk_reg;

    logic wr_en, ready, start, cfg_wr, cnt_done;
    logic unused_ok;

    assign wr_en    = cs & write;
    assign ready    = (state_reg == IDLE);
    assign start    = wr_en && (addr == 5'd2) && ready;
    assign cfg_wr   = wr_en && (addr == 5'd3) && ready;
    assign cnt_done = (cnt_reg == dvsr_reg);

    // The read strobe has no side effects and the upper write bits are unmapped.
    assign unused_ok = ^{read, wr_data[31:18]};

    // SCLK level for a given state; registered on every state change so the
    // output pin never glitches.
    function automatic logic sclk_for(state_t s, logic pol, logic pha);
        return pol ^ (((s == P1) & ~pha) | ((s == P0) & pha));
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ss_n_reg     <= '1;
            dvsr_reg     <= DVSR_RST;
            cpol_reg     <= 1'b0;
            cpha_reg     <= 1'b0;
            tx_reg       <= 8'h00;
            rx_shift_reg <= 8'h00;
            rx_data_reg  <= 8'h00;
            cnt_reg      <= 16'd0;
            n_reg        <= 3'd0;
            sclk_reg     <= 1'b0;
        end else begin
            if (wr_en && (addr == 5'd1))
                ss_n_reg <= wr_data[S-1:0];
            if (cfg_wr) begin
                dvsr_reg <= wr_data[15:0];
                cpol_reg <= wr_data[16];
                cpha_reg <= wr_data[17];
            end
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        tx_reg  <= wr_data[7:0];
                        cnt_reg <= 16'd0;
                        n_reg   <= 3'd0;
                        if (cpha_reg) begin
                            state_reg <= CPHA_DLY;
                            sclk_reg  <= sclk_for(CPHA_DLY, cpol_reg, cpha_reg);
                        end else begin
                            state_reg <= P0;
                            sclk_reg  <= sclk_for(P0, cpol_reg, cpha_reg);
                        end
                    end else if (cfg_wr) begin
                        sclk_reg <= wr_data[16];
                    end else begin
                        sclk_reg <= cpol_reg;
                    end
                end
                CPHA_DLY: begin
                    if (cnt_done) begin
                        state_reg <= P0;
                        cnt_reg   <= 16'd0;
                        sclk_reg  <= sclk_for(P0, cpol_reg, cpha_reg);
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                P0: begin
                    if (cnt_done) begin
                        rx_shift_reg <= {rx_shift_reg[6:0], spi_miso};
                        state_reg    <= P1;
                        cnt_reg      <= 16'd0;
                        sclk_reg     <= sclk_for(P1, cpol_reg, cpha_reg);
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
                default: begin // P1
                    if (cnt_done) begin
                        cnt_reg <= 16'd0;
                        if (n_reg == 3'd7) begin
                            state_reg   <= IDLE;
                            rx_data_reg <= rx_shift_reg;
                            sclk_reg    <= cpol_reg;
                        end else begin
                            tx_reg    <= {tx_reg[6:0], 1'b0};
                            n_reg     <= n_reg + 3'd1;
                            state_reg <= P0;
                            sclk_reg  <= sclk_for(P0, cpol_reg, cpha_reg);
                        end
                    end else begin
                        cnt_reg <= cnt_reg + 16'd1;
                    end
                end
            endcase
        end
    end

    assign spi_sclk = sclk_reg;
    assign spi_mosi = (state_reg != IDLE) & tx_reg[7];
    assign spi_ss_n = ss_n_reg;

    always_comb begin
        rd_data = 32'h0;
        if (addr == 5'd0)
            rd_data = {23'b0, ready, rx_data_reg};
    end

endmodule

// File: tb/tb_mmio_spi_core.sv
// Directed bench for mmio_spi_core: modes 0 and 3, busy-write rejection,
// mid-transfer reset, minimum divider and unmapped reads.
module tb_mmio_spi_core;
    localparam int S = 2;

    logic         clk = 1'b0;
    logic         reset, cs, read, write;
    logic [4:0]   addr;
    logic [31:0]  wr_data, rd_data;
    logic         spi_sclk, spi_mosi, spi_miso;
    logic [S-1:0] spi_ss_n;
    logic         loopback, miso_tie;

    int n_checks = 0;
    int n_fail   = 0;
    int len, rises;
    logic [7:0] bits;

    assign spi_miso = loopback ? spi_mosi : miso_tie;

    mmio_spi_core #(.S(S), .DVSR_RST(16'd49)) dut (
        .clk(clk), .reset(reset), .cs(cs), .read(read), .write(write),
        .addr(addr), .wr_data(wr_data), .rd_data(rd_data),
        .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
        .spi_ss_n(spi_ss_n)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d);
        cs = 1'b1; write = 1'b1; addr = a; wr_data = d;
        tick();
        cs = 1'b0; write = 1'b0; addr = 5'd0; wr_data = 32'h0;
        #1;
    endtask

    // Starts a transfer and measures ready-low cycles, SCLK rising edges and
    // the MOSI bit seen at each rising edge. Optionally writes reg 2 and reg 3
    // while busy.
    task automatic run_xfer(input logic [7:0] tx, input bit inject,
                            output int l, output int r, output logic [7:0] b);
        logic prev;
        prev = spi_sclk;
        l = 0; r = 0; b = 8'h00;
        bus_write(5'd2, {24'h0, tx});
        while (l < 2000) begin
            if (addr == 5'd0 && rd_data[8]) break;
            l++;
            if (spi_sclk && !prev) begin
                r++;
                b = {b[6:0], spi_mosi};
            end
            prev = spi_sclk;
            if (inject) begin
                if (l == 4)      begin cs = 1; write = 1; addr = 5'd2; wr_data = 32'h55; end
                else if (l == 5) begin addr = 5'd3; wr_data = 32'h0; end
                else if (l == 6) begin cs = 0; write = 0; addr = 5'd0; end
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1; cs = 0; read = 0; write = 0; addr = 0; wr_data = 0;
        loopback = 1'b1; miso_tie = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // 1: reset state
        check("rst_rd0", rd_data, 32'h0000_0100);
        check("rst_ss_n", {30'b0, spi_ss_n}, 32'h3);
        check("rst_sclk", {31'b0, spi_sclk}, 32'h0);
        check("rst_mosi", {31'b0, spi_mosi}, 32'h0);

        bus_write(5'd1, 32'h1);
        check("ss_n_write", {30'b0, spi_ss_n}, 32'h1);

        // 2: mode 0, dvsr 1, loopback
        bus_write(5'd3, 32'h0000_0001);
        run_xfer(8'hA5, 1'b0, len, rises, bits);
        check("m0_len", len, 32);
        check("m0_rises", rises, 8);
        check("m0_bits", {24'h0, bits}, 32'hA5);
        check("m0_rd0", rd_data, 32'h1A5);

        // 4: reg 2 / reg 3 writes while busy are ignored
        run_xfer(8'h5A, 1'b1, len, rises, bits);
        check("busy_len", len, 32);
        check("busy_rd0", rd_data, 32'h15A);
        run_xfer(8'h0F, 1'b0, len, rises, bits);
        check("busy_dvsr_len", len, 32);
        check("busy_rd0_2", rd_data, 32'h10F);

        // 3: mode 3, dvsr 3, miso tied high
        loopback = 1'b0; miso_tie = 1'b1;
        bus_write(5'd3, 32'h0003_0003);
        check("m3_idle_sclk", {31'b0, spi_sclk}, 32'h1);
        run_xfer(8'h3C, 1'b0, len, rises, bits);
        check("m3_len", len, 68);
        check("m3_rises", rises, 8);
        check("m3_bits", {24'h0, bits}, 32'h3C);
        check("m3_rd0", rd_data, 32'h1FF);
        check("m3_end_sclk", {31'b0, spi_sclk}, 32'h1);

        // 5: reset at cycle 10 of a transfer
        bus_write(5'd1, 32'h0);
        bus_write(5'd2, 32'hC3);
        repeat (9) tick();
        check("mid_busy", rd_data, 32'h0000_00FF);
        reset = 1'b1;
        tick();
        check("mid_rst_rd0", rd_data, 32'h0000_0100);
        check("mid_rst_sclk", {31'b0, spi_sclk}, 32'h0);
        check("mid_rst_ss_n", {30'b0, spi_ss_n}, 32'h3);
        check("mid_rst_mosi", {31'b0, spi_mosi}, 32'h0);
        reset = 1'b0;
        tick();

        // 6: dvsr 0, loopback, unmapped reads
        loopback = 1'b1;
        bus_write(5'd3, 32'h0);
        run_xfer(8'h81, 1'b0, len, rises, bits);
        check("d0_len", len, 16);
        check("d0_rises", rises, 8);
        check("d0_rd0", rd_data, 32'h181);
        addr = 5'd7; #1;
        check("rd_addr7", rd_data, 32'h0);
        addr = 5'd1; #1;
        check("rd_addr1", rd_data, 32'h0);
        addr = 5'd0; #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
